dmem_responder: RTL and testbench

- Target-side controller for the CPU's data-memory port. It answers the CPU's rd/wr/addr/data/byte_select signals with a ready handshake.
- Contains a word-organised on-chip RAM, a configurable wait-state counter and per-byte write merging.
- Stalls the pipeline by holding mem_ready_o low until each access completes. Keeps ready asserted while the completed request is still presented, so it can line up with the instruction-side ready.

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the CPU load/store port with wait states,
// byte-lane write merging and a ready handshake. Optional macro: DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  byte_select_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_data_o,
  output logic        err_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      addr_reg, wdata_reg;
  logic [3:0]       be_reg;
  logic             rd_reg, wr_reg;

  logic             req, same_req, launch, commit, ready_state;
  logic [ADDR_W-1:0] commit_idx;
  logic [31:0]      commit_wdata;
  logic [3:0]       commit_be;
  logic             commit_rd, commit_wr, commit_oor;
  logic             wr_en, rd_load, rd_zero;

  assign req      = mem_rd_i | mem_wr_i;
  assign same_req = req && ({mem_addr_i, mem_data_i, byte_select_i, mem_rd_i, mem_wr_i} ==
                            {addr_reg, wdata_reg, be_reg, rd_reg, wr_reg});

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    launch      = 1'b0;
    commit      = 1'b0;
    ready_state = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_state = !req;
        launch      = req;
      end
      ST_BUSY: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_DONE;
          commit     = 1'b1;
        end
      end
      ST_DONE: begin
        // A request identical to the one just served is a CPU stall: keep ready high.
        ready_state = !req || same_req;
        if (!req) state_next = ST_IDLE;
        else if (!same_req) launch = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (launch) begin
      if (WAIT_STATES == 0) begin
        state_next = ST_DONE;
        commit     = 1'b1;
      end else begin
        state_next = ST_BUSY;
        cnt_next   = CNT_W'(WAIT_STATES);
      end
    end
  end

  assign mem_ready_o = rst_i | ready_state;

  // With zero wait states the commit happens on the launch edge, so it uses live inputs.
  assign commit_idx   = launch ? mem_addr_i[ADDR_W+1:2] : addr_reg[ADDR_W+1:2];
  assign commit_wdata = launch ? mem_data_i    : wdata_reg;
  assign commit_be    = launch ? byte_select_i : be_reg;
  assign commit_rd    = launch ? mem_rd_i      : rd_reg;
  assign commit_wr    = launch ? mem_wr_i      : wr_reg;

  assign wr_en   = commit && commit_wr && !commit_oor && !rst_i;
  assign rd_load = commit && commit_rd && !commit_wr && !commit_oor;
  assign rd_zero = commit && commit_rd && (commit_wr || commit_oor);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (launch) begin
        addr_reg  <= mem_addr_i;
        wdata_reg <= mem_data_i;
        be_reg    <= byte_select_i;
        rd_reg    <= mem_rd_i;
        wr_reg    <= mem_wr_i;
      end
    end
  end

  // One byte-wide RAM per lane keeps the per-lane write enable a plain BRAM write.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk_i) begin
      if (wr_en && commit_be[gi]) ram[commit_idx] <= commit_wdata[gi*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) rdata_reg <= '0;
      else if (rd_load) rdata_reg <= ram[commit_idx];
      else if (rd_zero) rdata_reg <= '0;
    end

    assign mem_data_o[gi*8 +: 8] = rdata_reg;
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic [31-(ADDR_W+2):0] commit_hi;
  logic                   err_reg;

  assign commit_hi  = launch ? mem_addr_i[31:ADDR_W+2] : addr_reg[31:ADDR_W+2];
  assign commit_oor = |commit_hi;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_reg <= 1'b0;
    else if (commit && commit_oor) err_reg <= 1'b1;
  end

  assign err_o = err_reg;
`else
  assign commit_oor = 1'b0;
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: one instance with two wait
// states, one with none, both checked against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, rd, wr, ready, err;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  be;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(2), .CNT_W(4)) u_dut_ws2 (
    .clk_i(clk), .rst_i(rst[0]), .mem_rd_i(rd[0]), .mem_wr_i(wr[0]),
    .mem_addr_i(addr[0]), .mem_data_i(wdata[0]), .byte_select_i(be[0]),
    .mem_ready_o(ready[0]), .mem_data_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(0), .CNT_W(4)) u_dut_ws0 (
    .clk_i(clk), .rst_i(rst[1]), .mem_rd_i(rd[1]), .mem_wr_i(wr[1]),
    .mem_addr_i(addr[1]), .mem_data_i(wdata[1]), .byte_select_i(be[1]),
    .mem_ready_o(ready[1]), .mem_data_o(rdata[1]), .err_o(err[1])
  );

  // Reference model: plain word array per instance plus last served request.
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] model_data [2];
  logic        model_err [2];
  bit          held_valid [2];
  logic [69:0] held_key [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] pool [8];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a[31:ADDR_W+2] != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_commit(input int d, input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] dat, input logic [3:0] bsel);
    int idx;
    bit oor;
    idx = int'(a[ADDR_W+1:2]);
    oor = is_oor(a);
    if (oor) model_err[d] = 1'b1;
    if (w && !oor)
      for (int n = 0; n < 4; n++)
        if (bsel[n]) model_mem[d][idx][n*8 +: 8] = dat[n*8 +: 8];
    if (r) model_data[d] = (w || oor) ? 32'h0 : model_mem[d][idx];
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] bsel, input int hold,
                        input bit drop);
    logic [69:0] key;
    int lows;
    int exp_lows;
    key = {a, dat, bsel, r, w};
    exp_lows = (held_valid[d] && held_key[d] == key) ? 0 : ws_of(d) + 1;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dat; be[d] = bsel;
    lows = 0;
    @(negedge clk);
    while (!ready[d] && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    if (exp_lows != 0) model_commit(d, r, w, a, dat, bsel);
    $display("txn dut=%0d rd=%0b wr=%0b addr=%08h wdata=%08h be=%b lat=%0d rdata=%08h err=%0b",
             d, r, w, a, dat, bsel, lows, rdata[d], err[d]);
    check_value("latency", 32'(lows), 32'(exp_lows));
    check_value("rdata", rdata[d], model_data[d]);
    check_value("err", 32'(err[d]), 32'(model_err[d]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_value("hold_ready", 32'(ready[d]), 32'h1);
      check_value("hold_rdata", rdata[d], model_data[d]);
    end
    @(posedge clk); #1;
    held_valid[d] = 1'b1;
    held_key[d]   = key;
    if (drop) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(negedge clk);
      check_value("idle_ready", 32'(ready[d]), 32'h1);
      @(posedge clk); #1;
      held_valid[d] = 1'b0;
    end
  endtask

  task automatic busy_reset_write(input logic [31:0] a, input logic [31:0] dat);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = a; wdata[0] = dat; be[0] = 4'hF;
    @(negedge clk);
    check_value("rst_req_low", 32'(ready[0]), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(negedge clk);
    check_value("rst_forced_ready", 32'(ready[0]), 32'h1);
    @(posedge clk); #1;
    rst[0] = 1'b0; wr[0] = 1'b0;
    model_data[0] = 32'h0;
    model_err[0]  = 1'b0;
    held_valid[0] = 1'b0;
    @(negedge clk);
    $display("txn dut=0 reset during busy write addr=%08h ready=%0b", a, ready[0]);
    check_value("post_rst_ready", 32'(ready[0]), 32'h1);
    check_value("post_rst_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0010; pool[2] = 32'h0000_0014;
    pool[3] = 32'h0000_0020; pool[4] = 32'h0000_0040; pool[5] = 32'h0000_0084;
    pool[6] = 32'h0000_0FFC; pool[7] = 32'h0000_03F0;
    for (int d = 0; d < 2; d++) begin
      model_data[d] = 32'h0; model_err[d] = 1'b0; held_valid[d] = 1'b0; held_key[d] = '0;
    end
    rst = 2'b11; rd = '0; wr = '0; addr = '0; wdata = '0; be = '0;

    @(negedge clk);
    check_value("rst_ready0", 32'(ready[0]), 32'h1);
    check_value("rst_ready1", 32'(ready[1]), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check_value("rst_rdata0", rdata[0], 32'h0);
    check_value("rst_rdata1", rdata[1], 32'h0);
    check_value("rst_err0", 32'(err[0]), 32'h0);
    @(posedge clk); #1;
    rst = 2'b00;
    @(negedge clk);
    check_value("idle_ready0", 32'(ready[0]), 32'h1);
    check_value("idle_ready1", 32'(ready[1]), 32'h1);
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        access(d, 1'b0, 1'b1, pool[i], $urandom, 4'hF, 0, 1'b1);

    // Full-word write then read-back, byte merge, held read, address change.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1);
    check_value("plan_word", rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 0, 1'b1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1);
    check_value("plan_merge", rdata[0], 32'hDEADABEF);
    access(0, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 4'h0, 0, 1'b1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0);
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b1);

    busy_reset_write(32'h20, 32'h11111111);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1);

    // Zero wait states, including back-to-back distinct reads.
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b1);

    // Upper address bits: aliasing or range error depending on the build.
    access(0, 1'b0, 1'b1, 32'h0000_1000, 32'h55, 4'hF, 0, 1'b1);
`ifdef DMEM_RANGE_CHECK_EN
    check_value("range_err_set", 32'(err[0]), 32'h1);
`else
    check_value("range_err_tied", 32'(err[0]), 32'h0);
`endif
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1);
`ifndef DMEM_RANGE_CHECK_EN
    check_value("alias_read", rdata[0], 32'h55);
`endif

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        logic [31:0] a, dat;
        logic [3:0]  bsel;
        logic        r, w;
        int          kind;
        if (held_valid[d] && $urandom_range(0, 7) == 0) begin
          {a, dat, bsel, r, w} = held_key[d];
        end else begin
          a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) a = a | ($urandom << 12);
          dat  = $urandom;
          bsel = 4'($urandom_range(0, 15));
          kind = $urandom_range(0, 19);
          r = (kind < 9) || (kind >= 18);
          w = (kind >= 9);
        end
        access(d, r, w, a, dat, bsel, $urandom_range(0, 3), $urandom_range(0, 2) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
